writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Write-side driver for the CPU register file: collects results from the ALU path and the load
//  path and emits at most one (din, writeEnable, rd) write per cycle. Buffers ALU results in a
//  small FIFO and always gives priority to load data, since the memory path cannot stall.
//  Keeps a pending-write scoreboard so decode can detect RAW hazards on rs/rt.
// PARAMETERS
//  DATA_W      32  result/data width
//  ADDR_W      5   register index width (32 registers)
//  FIFO_DEPTH  4   ALU result buffer entries (power of 2, >=2)
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               reset, asynchronous, active-low
//  ld_valid   in   1               load result valid this cycle (no backpressure)
//  ld_rd      in   ADDR_W          load destination register
//  ld_data    in   DATA_W          load data
//  alu_valid  in   1               ALU result offered
//  alu_ready  out  1               unit accepts ALU result (transfer = valid & ready)
//  alu_rd     in   ADDR_W          ALU destination register
//  alu_data   in   DATA_W          ALU result
//  iss_valid  in   1               instruction with a destination issued
//  iss_rd     in   ADDR_W          issued destination register
//  rs, rt     in   ADDR_W          decode source registers to check
//  hazard_a   out  1               pending[rs] (combinational)
//  hazard_b   out  1               pending[rt] (combinational)
//  wb_we      out  1               register file writeEnable (registered)
//  wb_rd      out  ADDR_W          register file rd (registered)
//  wb_din     out  DATA_W          register file din (registered)
//  fifo_count out  clog2(DEPTH)+1  ALU FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, async): wb_we=0, wb_rd=0, wb_din=0, FIFO empty, fifo_count=0, pending=0,
//   alu_ready=0 while rst is low. Reset mid-operation discards all buffered results.
//  alu_ready = (fifo_count < FIFO_DEPTH) when not in reset. This depends on count only:
//   no push into a full FIFO, even in a cycle that pops.
//  Output selection, evaluated each rising edge, in priority order:
//   1) ld_valid & ld_rd!=0: wb_we<=1, wb_rd<=ld_rd, wb_din<=ld_data. FIFO does not pop.
//      Any accepted ALU result is enqueued.
//   2) else FIFO non-empty: pop head into wb_*, wb_we<=1. Any accepted ALU result is enqueued
//      (same-edge push+pop is legal when not full).
//   3) else accepted ALU result with rd!=0: bypasses the FIFO straight to wb_*, wb_we<=1.
//   4) else wb_we<=0. wb_rd and wb_din hold their previous values.
//  Latency: load 1 cycle. ALU 1 cycle when bypassing, otherwise 1 cycle after reaching the FIFO head.
//  Writes to rd=0 are dropped: an ALU transfer is still accepted (handshake completes) but is not
//   enqueued; a load with ld_rd=0 is ignored and does not block a FIFO pop.
//  FIFO ordering: strict FIFO among ALU results. Loads may overtake ALU results.
//  Pointers wrap modulo FIFO_DEPTH.
//  Scoreboard pending[31:0], pending[0] always 0:
//   - set: iss_valid & iss_rd!=0 -> pending[iss_rd]<=1
//   - clear: wb_we & (pending bit index == wb_rd) at the edge the register file commits the write
//   - set and clear on the same register in the same cycle: set wins (a newer writer is pending)
//   - hazard_a = pending[rs], hazard_b = pending[rt]; rs=0 or rt=0 -> 0.
// TESTING
//  T1 reset: hold rst=0 with ld_valid=1 -> wb_we=0, alu_ready=0, fifo_count=0, hazards 0.
//  T2 bypass: idle, ALU rd=5 data=32'h1234 -> next cycle wb_we=1, wb_rd=5, wb_din=32'h1234,
//     fifo_count stays 0.
//  T3 priority: ld rd=3 data=AA together with ALU rd=4 data=BB -> cycle1 writes r3=AA,
//     cycle2 writes r4=BB, count 1 then 0.
//  T4 full: ld_valid held high for 6 cycles, ALU streams rd=1..6 -> 4 accepted, alu_ready=0 at
//     count 4; after loads stop, r1..r4 written in order.
//  T5 r0: ALU rd=0 and ld rd=0 -> handshake completes, wb_we stays 0, FIFO unchanged.
//  T6 scoreboard: iss rd=7 -> hazard_a=1 for rs=7; write r7 clears it; iss rd=7 on the same
//     clear edge -> hazard_a remains 1.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Register-file writeback bus: load/ALU result inputs, issue/decode hazard query, and the write port.
interface writeback_unit_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              hazard_a;
  logic              hazard_b;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_din;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, iss_valid, iss_rd, rs, rt,
    input  alu_ready, hazard_a, hazard_b, wb_we, wb_rd, wb_din, fifo_count
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, iss_valid, iss_rd, rs, rt,
    output alu_ready, hazard_a, hazard_b, wb_we, wb_rd, wb_din, fifo_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write driver: load results take priority, ALU results are buffered in a FIFO,
// and a pending-write scoreboard reports RAW hazards to decode.
module writeback_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  writeback_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_din;
  logic [NREG-1:0]   r_pending;

  logic              w_full;
  logic              w_empty;
  logic              w_alu_acc;
  logic              w_alu_wr;
  logic              w_ld_wr;
  logic              w_pop;
  logic              w_push;
  logic              w_bypass;
  wb_entry_t         w_head;
  logic [NREG-1:0]   w_pending_nxt;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_alu_acc = bus.alu_valid & bus.alu_ready;
  assign w_alu_wr  = w_alu_acc & (bus.alu_rd != '0);
  assign w_ld_wr   = bus.ld_valid & (bus.ld_rd != '0);
  assign w_pop     = ~w_ld_wr & ~w_empty;
  // An ALU result only skips the FIFO when nothing else wants the write port this cycle.
  assign w_bypass  = w_alu_wr & ~w_ld_wr & w_empty;
  assign w_push    = w_alu_wr & ~w_bypass;
  assign w_head    = r_mem[r_rd_ptr];

  assign bus.alu_ready  = rst & ~w_full;
  assign bus.hazard_a   = r_pending[bus.rs];
  assign bus.hazard_b   = r_pending[bus.rt];
  assign bus.wb_we      = r_wb_we;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_din     = r_wb_din;
  assign bus.fifo_count = r_count;

  // FIFO payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Write port: load, then FIFO head, then ALU bypass; rd/din hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_we  <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_din <= '0;
    end else if (w_ld_wr) begin
      r_wb_we  <= 1'b1;
      r_wb_rd  <= bus.ld_rd;
      r_wb_din <= bus.ld_data;
    end else if (w_pop) begin
      r_wb_we  <= 1'b1;
      r_wb_rd  <= w_head.rd;
      r_wb_din <= w_head.data;
    end else if (w_bypass) begin
      r_wb_we  <= 1'b1;
      r_wb_rd  <= bus.alu_rd;
      r_wb_din <= bus.alu_data;
    end else begin
      r_wb_we  <= 1'b0;
    end
  end

  // Clear on register-file commit, then set on issue so a newer writer stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wb_we) w_pending_nxt[r_wb_rd] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) w_pending_nxt[bus.iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) bus ();

  writeback_unit #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd,
                        input logic [31:0] din, input logic [2:0] cnt);
    chk({tag, ".we"},  32'(bus.wb_we), 32'(we));
    chk({tag, ".rd"},  32'(bus.wb_rd), 32'(rd));
    chk({tag, ".din"}, bus.wb_din, din);
    chk({tag, ".cnt"}, 32'(bus.fifo_count), 32'(cnt));
  endtask

  initial begin
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'hFFFF_0000;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h55;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs = 5'd7; bus.rt = 5'd6;

    // T1: reset held with activity on every input
    repeat (3) tick();
    chk_wb("t1_reset", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("t1_ready", 32'(bus.alu_ready), 32'd0);
    chk("t1_haz_a", 32'(bus.hazard_a), 32'd0);
    chk("t1_haz_b", 32'(bus.hazard_b), 32'd0);

    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0; bus.iss_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t1_ready_after", 32'(bus.alu_ready), 32'd1);

    // T2: ALU bypass into an idle unit
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    tick();
    chk_wb("t2_bypass", 1'b1, 5'd5, 32'h1234, 3'd0);
    bus.alu_valid = 1'b0;
    tick();
    chk_wb("t2_idle_hold", 1'b0, 5'd5, 32'h1234, 3'd0);

    // T3: load beats simultaneous ALU result
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'hAA;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hBB;
    tick();
    chk_wb("t3_c1", 1'b1, 5'd3, 32'hAA, 3'd1);
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    tick();
    chk_wb("t3_c2", 1'b1, 5'd4, 32'hBB, 3'd0);
    tick();
    chk_wb("t3_c3", 1'b0, 5'd4, 32'hBB, 3'd0);

    // T4: loads every cycle while ALU streams rd=1..6; FIFO fills at 4
    begin
      int nxt = 1;
      for (int i = 0; i < 6; i++) begin
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'(100 + i);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'(nxt); bus.alu_data = 32'(8'hA0 + nxt);
        #1;
        chk($sformatf("t4_ready%0d", i), 32'(bus.alu_ready), (i < 4) ? 32'd1 : 32'd0);
        tick();
        chk_wb($sformatf("t4_ld%0d", i), 1'b1, 5'd10, 32'(100 + i), (i < 3) ? 3'(i + 1) : 3'd4);
        if (i < 4) nxt++;
      end
    end
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_wb($sformatf("t4_drain%0d", k), 1'b1, 5'(k), 32'(8'hA0 + k), 3'(4 - k));
    end
    tick();
    chk_wb("t4_done", 1'b0, 5'd4, 32'hA4, 3'd0);
    chk("t4_ready_after", 32'(bus.alu_ready), 32'd1);

    // T5: writes to r0 are dropped but the ALU handshake still completes
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hDEAD;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBEEF;
    #1;
    chk("t5_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk_wb("t5_r0", 1'b0, 5'd4, 32'hA4, 3'd0);
    // a load to r0 must not block a FIFO pop
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    tick();
    chk_wb("t5_pre", 1'b1, 5'd9, 32'h99, 3'd1);
    bus.ld_rd = 5'd0; bus.alu_valid = 1'b0;
    tick();
    chk_wb("t5_pop_past_r0", 1'b1, 5'd2, 32'h22, 3'd0);
    bus.ld_valid = 1'b0;
    tick();

    // T6: scoreboard set, clear on commit, set wins over clear
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs = 5'd7; bus.rt = 5'd8;
    #1;
    chk("t6_haz_before", 32'(bus.hazard_a), 32'd0);
    tick();
    chk("t6_haz_set", 32'(bus.hazard_a), 32'd1);
    chk("t6_haz_b", 32'(bus.hazard_b), 32'd0);
    bus.iss_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h77;
    tick();
    chk("t6_wb_r7", 32'(bus.wb_rd), 32'd7);
    chk("t6_haz_until_commit", 32'(bus.hazard_a), 32'd1);
    bus.ld_valid = 1'b0;
    tick();
    chk("t6_haz_cleared", 32'(bus.hazard_a), 32'd0);
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    bus.ld_valid = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.iss_valid = 1'b1;
    tick();
    chk("t6_set_wins", 32'(bus.hazard_a), 32'd1);
    bus.iss_valid = 1'b0;
    tick();
    chk("t6_still_pending", 32'(bus.hazard_a), 32'd1);
    bus.rt = 5'd0;
    #1;
    chk("t6_rt_zero", 32'(bus.hazard_b), 32'd0);

    // Mid-operation reset discards buffered results
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd11; bus.ld_data = 32'hB1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC2;
    tick();
    chk_wb("rst_pre", 1'b1, 5'd11, 32'hB1, 3'd1);
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_wb("rst_async", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("rst_haz", 32'(bus.hazard_a), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk_wb("rst_discard", 1'b0, 5'd0, 32'h0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
